// File: rtl/dfp_cacheline_adapter.sv
// dfp_cacheline_adapter: bridges cache-line DFP requests to a 4-beat burst memory.
// Each line read is issued as one burst request and its returning beats are
// reassembled into a line. Each line write is streamed out as beats.
// Optional build macro DFP_ADAPTER_RADDR_CHECK_EN: drop read beats whose
// bmem_raddr line does not match the outstanding request.
module dfp_cacheline_adapter #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Reject geometries where the line is not a power-of-two number (>=2) of beats
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || BEATS * BEAT_BITS != LINE_BITS) begin : g_param_err
        $error("dfp_cacheline_adapter: LINE_BITS/BEAT_BITS must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [LINE_BITS-1:0] line_buf;
    logic [LINE_BITS-1:0] line_merged;
    logic                 beat_ok;
    logic                 unused_bits;

    assign cnt_inc = cnt + CNT_W'(1);

    // Line buffer with the current read beat dropped into its slot
    always_comb begin
        line_merged = line_buf;
        line_merged[32'(cnt) * BEAT_BITS +: BEAT_BITS] = bmem_rdata;
    end

    // Qualify returning read beats; bmem_addr holds the latched line address
`ifdef DFP_ADAPTER_RADDR_CHECK_EN
    assign beat_ok = bmem_rvalid && (bmem_raddr[31:5] == bmem_addr[31:5]);
`else
    assign beat_ok = bmem_rvalid;
`endif

    assign unused_bits = ^{dfp_addr[4:0], bmem_raddr};

    // Request sequencing, beat counting, line assembly and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            line_buf   <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            dfp_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (dfp_write) begin
                        bmem_addr  <= {dfp_addr[31:5], 5'b0};
                        line_buf   <= dfp_wdata;
                        bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
                        bmem_write <= 1'b1;
                        cnt        <= '0;
                        state      <= WR_BURST;
                    end else if (dfp_read) begin
                        bmem_addr <= {dfp_addr[31:5], 5'b0};
                        bmem_read <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        cnt       <= '0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (beat_ok) begin
                        line_buf <= line_merged;
                        cnt      <= cnt_inc;
                        if (cnt == LAST_BEAT) begin
                            dfp_rdata <= line_merged;
                            dfp_resp  <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        cnt        <= cnt_inc;
                        bmem_wdata <= line_buf[32'(cnt_inc) * BEAT_BITS +: BEAT_BITS];
                        if (cnt == LAST_BEAT) begin
                            bmem_write <= 1'b0;
                            dfp_resp   <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dfp_cacheline_adapter.md
Name: dfp_cacheline_adapter

Overview:
- Memory-side responder for the cache DFP interface (line address, read/write strobes, 256-bit line data, single-cycle resp).
- Converts each line request into a 4-beat, 64-bit burst on the backing-memory (bmem) port.
- Reassembles read beats into a full line and returns one dfp_resp pulse per request.
- Sits between the L1 data/instruction caches (or their arbiter) and the banked burst memory.

Parameters:
- LINE_BITS, 256, DFP line width in bits.
- BEAT_BITS, 64, bmem data width in bits. BEATS = LINE_BITS/BEAT_BITS; must be a power of two and ≥2 (elaboration error otherwise).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dfp_addr  in  32  line address; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  LINE_BITS  write line
- dfp_rdata  out  LINE_BITS  read line, valid when dfp_resp
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst line address, {line[31:5],5'b0}
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_BITS  write beat
- bmem_ready  in  1  memory accepts request/beat this cycle
- bmem_raddr  in  32  address tag of returning read beat
- bmem_rdata  in  BEAT_BITS  read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0, all outputs 0, line buffer 0. Reset mid-burst abandons the burst; no dfp_resp is issued. Stray bmem_rvalid beats after reset are ignored in IDLE.
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE:
  - dfp_write=1: latch {dfp_addr[31:5],5'b0} and dfp_wdata, cnt=0, go to WR_BURST.
  - Else dfp_read=1: latch address, go to RD_REQ.
  - Both asserted: write wins; read is ignored.
  - Requests are sampled only in IDLE; input changes while busy are ignored.
- RD_REQ: bmem_read=1, bmem_addr=latched. When bmem_ready=1, go to RD_DATA with cnt=0. bmem_read drops the following cycle.
- RD_DATA:
  - Each bmem_rvalid writes bmem_rdata into buffer[cnt*BEAT_BITS +: BEAT_BITS], then cnt++.
  - Beat 0 is line bits [63:0]; beats fill in ascending order.
  - On the rvalid with cnt==BEATS-1, go to RESP.
  - Gaps between beats are allowed.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched, bmem_wdata = wline[cnt*BEAT_BITS +: BEAT_BITS].
  - Each cycle with bmem_ready=1 accepts a beat, cnt++.
  - The beat with cnt==BEATS-1 accepted → RESP.
  - bmem_write stays high across stalls, with wdata stable.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE.
  - dfp_rdata = assembled line after reads; after writes it is unchanged from the previous read line.
  - dfp_rdata holds its value until the next read completes.
- Back-to-back requests: a request still asserted in the IDLE cycle after RESP is accepted as a new request. This covers the cache re-issuing after a stale or mismatched response.
- Minimum latency, request asserted in IDLE at cycle 0, bmem always ready:
  - Read: RD_REQ at 1, beats at 2..5 (earliest), dfp_resp at cycle 6.
  - Write: beats at 1..4, dfp_resp at cycle 5.
- cnt is log2(BEATS) bits; it wraps to 0 after the last beat and never wraps mid-burst.

Optional Feature:
- Macro DFP_ADAPTER_RADDR_CHECK_EN.
- When defined: in RD_DATA a beat is accepted only if bmem_raddr[31:5] equals the latched line address. Mismatched beats are dropped; cnt and buffer are unchanged.
- When undefined: bmem_raddr is unused and every bmem_rvalid beat in RD_DATA is accepted.

Test Plan:
- Read 0x0000_1240, bmem ready immediately, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → bmem_addr=0x0000_1240, dfp_resp at cycle 6, dfp_rdata = {0x44..44,0x33..33,0x22..22,0x11..11}.
- Write 0xABCD_0020, wdata = {4{64'hDEAD_BEEF_0000_000k}} with k=beat index, bmem_ready low for 2 cycles before beat 2 → bmem_wdata stays at beat 2 value while stalled, 4 accepted beats, dfp_resp single pulse.
- dfp_read and dfp_write both high in IDLE → write burst only, bmem_read never asserted.
- rst_n pulsed low after 2 read beats → all outputs 0 asynchronously, no dfp_resp. A new read then completes normally with fresh data.
- dfp_read held high through RESP → second burst starts the cycle after dfp_resp, exactly 2 dfp_resp pulses for 2 bursts.
- DFP_ADAPTER_RADDR_CHECK_EN defined: inject rvalid with raddr 0x0000_2000 during a read of 0x0000_1240 → beat dropped, line assembles from the 4 matching beats only, resp one cycle later than without the injected beat.
